// File: rtl/input_pkg.sv
// Shared definitions for the input conditioner: player-word bit positions,
// PS/2 scan codes, the coin FSM state type and the direction-conflict filter.
package input_pkg;

    localparam int PLAYER_W  = 10;

    localparam int IDX_RIGHT = 0;
    localparam int IDX_LEFT  = 1;
    localparam int IDX_DOWN  = 2;
    localparam int IDX_UP    = 3;
    localparam int IDX_B1    = 4;
    localparam int IDX_B2    = 5;
    localparam int IDX_B3    = 6;
    localparam int IDX_START = 7;
    localparam int IDX_COIN  = 8;
    localparam int IDX_PAUSE = 9;

    localparam logic [7:0] SC_UP1     = 8'h75;
    localparam logic [7:0] SC_DOWN1   = 8'h72;
    localparam logic [7:0] SC_LEFT1   = 8'h6B;
    localparam logic [7:0] SC_RIGHT1  = 8'h74;
    localparam logic [7:0] SC_B1_1    = 8'h14;
    localparam logic [7:0] SC_B2_1    = 8'h11;
    localparam logic [7:0] SC_B3_1    = 8'h29;
    localparam logic [7:0] SC_START1  = 8'h16;
    localparam logic [7:0] SC_COIN1   = 8'h2E;
    localparam logic [7:0] SC_PAUSE1  = 8'h4D;
    localparam logic [7:0] SC_UP2     = 8'h2D;
    localparam logic [7:0] SC_DOWN2   = 8'h2B;
    localparam logic [7:0] SC_LEFT2   = 8'h23;
    localparam logic [7:0] SC_RIGHT2  = 8'h34;
    localparam logic [7:0] SC_B1_2    = 8'h1C;
    localparam logic [7:0] SC_B2_2    = 8'h1B;
    localparam logic [7:0] SC_B3_2    = 8'h15;
    localparam logic [7:0] SC_START2  = 8'h1E;
    localparam logic [7:0] SC_COIN2   = 8'h36;
    localparam logic [7:0] SC_SERVICE1 = 8'h46;
    localparam logic [7:0] SC_SERVICE2 = 8'h45;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        WAIT_RELEASE
    } coin_state_t;

    // Opposing directions held together cancel; each axis is judged on its own.
    function automatic logic [PLAYER_W-1:0] filter_dirs(input logic [PLAYER_W-1:0] raw);
        logic [PLAYER_W-1:0] f;
        f = raw;
        if (raw[IDX_UP] && raw[IDX_DOWN]) begin
            f[IDX_UP]   = 1'b0;
            f[IDX_DOWN] = 1'b0;
        end
        if (raw[IDX_LEFT] && raw[IDX_RIGHT]) begin
            f[IDX_LEFT]  = 1'b0;
            f[IDX_RIGHT] = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/coin_pulse.sv
// Shapes a raw coin level into one fixed-width pulse followed by a lockout;
// a held coin yields a single pulse and must be released before the next.
module coin_pulse
    import input_pkg::*;
#(
    parameter int unsigned COIN_PULSE_CYCLES = 4_000_000,
    parameter int unsigned COIN_GAP_CYCLES   = 8_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic coin_in,
    output logic coin_out
);

    localparam int unsigned CNT_TOP = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ?
                                      COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
    localparam int CNT_W = $clog2(CNT_TOP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CNT_TOP);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(COIN_GAP_CYCLES - 1);

    coin_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             coin_q, coin_d;
    logic             prev_q, prev_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        coin_d  = coin_q;
        prev_d  = coin_in;
        case (state_q)
            IDLE: begin
                if (coin_in && !prev_q) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                    coin_d  = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    coin_d  = 1'b0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = coin_in ? WAIT_RELEASE : IDLE;
                end
            end
            WAIT_RELEASE: begin
                if (!coin_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge register resets high so a coin held through reset never fires.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            coin_q  <= 1'b0;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coin_q  <= coin_d;
            prev_q  <= prev_d;
        end
    end

    assign coin_out = coin_q;

endmodule

// File: rtl/input_conditioner.sv
// Merges PS/2 held-key state with HPS joystick words, filters direction
// conflicts, shapes coin pulses and provides a toggle or level pause.
module input_conditioner
    import input_pkg::*;
#(
    parameter int unsigned COIN_PULSE_CYCLES = 4_000_000,
    parameter int unsigned COIN_GAP_CYCLES   = 8_000_000,
    parameter int unsigned PAUSE_TOGGLE      = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [10:0]         ps2_key,
    input  logic [10:0]         joystick_0,
    input  logic [10:0]         joystick_1,
    output logic [PLAYER_W-1:0] player1,
    output logic [PLAYER_W-1:0] player2,
    output logic                service1,
    output logic                service2
);

    logic                tog_q, tog_d;
    logic [PLAYER_W-1:0] key1_q, key1_d;
    logic [PLAYER_W-1:0] key2_q, key2_d;
    logic [1:0]          svc_key_q, svc_key_d;
    logic [7:0]          out1_q, out1_d;
    logic [7:0]          out2_q, out2_d;
    logic [1:0]          svc_q, svc_d;
    logic [1:0]          pause_prev_q, pause_prev_d;
    logic [1:0]          pause_q, pause_d;

    logic                ps2_event;
    logic [PLAYER_W-1:0] raw1, raw2, filt1, filt2;
    logic [1:0]          pause_raw, pause_rise;
    logic                coin1, coin2;
    logic                unused_bits;

    assign unused_bits = ^{ps2_key[8], joystick_0[10], joystick_1[10]};

    always_comb begin
        ps2_event = ps2_key[10] ^ tog_q;
        tog_d     = ps2_key[10];
        key1_d    = key1_q;
        key2_d    = key2_q;
        svc_key_d = svc_key_q;
        if (ps2_event) begin
            case (ps2_key[7:0])
                SC_UP1:      key1_d[IDX_UP]    = ps2_key[9];
                SC_DOWN1:    key1_d[IDX_DOWN]  = ps2_key[9];
                SC_LEFT1:    key1_d[IDX_LEFT]  = ps2_key[9];
                SC_RIGHT1:   key1_d[IDX_RIGHT] = ps2_key[9];
                SC_B1_1:     key1_d[IDX_B1]    = ps2_key[9];
                SC_B2_1:     key1_d[IDX_B2]    = ps2_key[9];
                SC_B3_1:     key1_d[IDX_B3]    = ps2_key[9];
                SC_START1:   key1_d[IDX_START] = ps2_key[9];
                SC_COIN1:    key1_d[IDX_COIN]  = ps2_key[9];
                SC_PAUSE1:   key1_d[IDX_PAUSE] = ps2_key[9];
                SC_UP2:      key2_d[IDX_UP]    = ps2_key[9];
                SC_DOWN2:    key2_d[IDX_DOWN]  = ps2_key[9];
                SC_LEFT2:    key2_d[IDX_LEFT]  = ps2_key[9];
                SC_RIGHT2:   key2_d[IDX_RIGHT] = ps2_key[9];
                SC_B1_2:     key2_d[IDX_B1]    = ps2_key[9];
                SC_B2_2:     key2_d[IDX_B2]    = ps2_key[9];
                SC_B3_2:     key2_d[IDX_B3]    = ps2_key[9];
                SC_START2:   key2_d[IDX_START] = ps2_key[9];
                SC_COIN2:    key2_d[IDX_COIN]  = ps2_key[9];
                SC_SERVICE1: svc_key_d[0]      = ps2_key[9];
                SC_SERVICE2: svc_key_d[1]      = ps2_key[9];
                default:     ;
            endcase
        end

        raw1   = key1_q | joystick_0[PLAYER_W-1:0];
        raw2   = key2_q | joystick_1[PLAYER_W-1:0];
        filt1  = filter_dirs(raw1);
        filt2  = filter_dirs(raw2);
        out1_d = filt1[7:0];
        out2_d = filt2[7:0];
        svc_d  = svc_key_q;

        // Key and joystick pause are merged before edge detection.
        pause_raw    = {raw2[IDX_PAUSE], raw1[IDX_PAUSE]};
        pause_rise   = pause_raw & ~pause_prev_q;
        pause_prev_d = pause_raw;
        pause_d      = (PAUSE_TOGGLE != 0) ? (pause_q ^ pause_rise) : pause_raw;
    end

    always_ff @(posedge clock) begin
        tog_q <= tog_d;
        if (reset) begin
            key1_q       <= '0;
            key2_q       <= '0;
            svc_key_q    <= '0;
            out1_q       <= '0;
            out2_q       <= '0;
            svc_q        <= '0;
            pause_prev_q <= 2'b11;
            pause_q      <= '0;
        end else begin
            key1_q       <= key1_d;
            key2_q       <= key2_d;
            svc_key_q    <= svc_key_d;
            out1_q       <= out1_d;
            out2_q       <= out2_d;
            svc_q        <= svc_d;
            pause_prev_q <= pause_prev_d;
            pause_q      <= pause_d;
        end
    end

    coin_pulse #(
        .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES),
        .COIN_GAP_CYCLES  (COIN_GAP_CYCLES)
    ) u_coin1 (
        .clock   (clock),
        .reset   (reset),
        .coin_in (raw1[IDX_COIN]),
        .coin_out(coin1)
    );

    coin_pulse #(
        .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES),
        .COIN_GAP_CYCLES  (COIN_GAP_CYCLES)
    ) u_coin2 (
        .clock   (clock),
        .reset   (reset),
        .coin_in (raw2[IDX_COIN]),
        .coin_out(coin2)
    );

    assign player1  = {pause_q[0], coin1, out1_q};
    assign player2  = {pause_q[1], coin2, out2_q};
    assign service1 = svc_q[0];
    assign service2 = svc_q[1];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized checks of input_conditioner against a cycle-stamped
// model of held keys, coin pulse windows and pause toggling.
module tb_input_conditioner;

    localparam int P = 4;
    localparam int G = 6;
    localparam int NKEYS = 21;

    logic        clock;
    logic        reset;
    logic [10:0] ps2_key;
    logic [10:0] joystick_0;
    logic [10:0] joystick_1;
    logic [9:0]  player1;
    logic [9:0]  player2;
    logic        service1;
    logic        service2;

    input_conditioner #(
        .COIN_PULSE_CYCLES(P),
        .COIN_GAP_CYCLES  (G),
        .PAUSE_TOGGLE     (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .joystick_0(joystick_0),
        .joystick_1(joystick_1),
        .player1   (player1),
        .player2   (player2),
        .service1  (service1),
        .service2  (service2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Key table: slot 0..9 = player1 bit, 10..19 = player2 bit, 20/21 = service.
    logic [7:0] key_code [NKEYS] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29,
                                     8'h16, 8'h2E, 8'h4D, 8'h2D, 8'h2B, 8'h23, 8'h34,
                                     8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36, 8'h46, 8'h45};
    int key_slot [NKEYS] = '{3, 2, 1, 0, 4, 5, 6, 7, 8, 9, 13, 12, 11, 10,
                             14, 15, 16, 17, 18, 20, 21};

    int checks = 0;
    int errors = 0;

    bit held [22];
    bit last_tog;
    bit coin_prev [2];
    bit pause_prev [2];
    bit pause_lat [2];
    int pulse_until [2];
    int lockout [2];
    int cyc = 0;

    int coin_hi;
    int coin_rises;
    bit coin_obs_prev;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs after this edge, advance, compare.
    task automatic tick();
        logic [9:0] raw [2];
        logic [9:0] e [2];
        logic [9:0] j [2];
        logic       es1, es2;
        e[0] = '0;
        e[1] = '0;
        es1  = 1'b0;
        es2  = 1'b0;
        if (reset) begin
            foreach (held[k]) held[k] = 1'b0;
            last_tog = ps2_key[10];
            for (int p = 0; p < 2; p++) begin
                coin_prev[p]   = 1'b1;
                pause_prev[p]  = 1'b1;
                pause_lat[p]   = 1'b0;
                pulse_until[p] = 0;
                lockout[p]     = 0;
            end
        end else begin
            j[0] = joystick_0[9:0];
            j[1] = joystick_1[9:0];
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < 10; b++) raw[p][b] = held[p*10+b] | j[p][b];
                e[p] = raw[p];
                if (raw[p][3] && raw[p][2]) e[p][3:2] = 2'b00;
                if (raw[p][1] && raw[p][0]) e[p][1:0] = 2'b00;
                if (raw[p][8] && !coin_prev[p] && cyc >= lockout[p]) begin
                    pulse_until[p] = cyc + P;
                    lockout[p]     = cyc + P + G + 1;
                end
                coin_prev[p] = raw[p][8];
                e[p][8] = (cyc < pulse_until[p]);
                if (raw[p][9] && !pause_prev[p]) pause_lat[p] = ~pause_lat[p];
                pause_prev[p] = raw[p][9];
                e[p][9] = pause_lat[p];
            end
            es1 = held[20];
            es2 = held[21];
            if (ps2_key[10] != last_tog) begin
                for (int k = 0; k < NKEYS; k++)
                    if (key_code[k] == ps2_key[7:0]) held[key_slot[k]] = ps2_key[9];
            end
            last_tog = ps2_key[10];
        end
        @(posedge clock);
        #1;
        check("player1", player1, e[0]);
        check("player2", player2, e[1]);
        check("service1", {9'b0, service1}, {9'b0, es1});
        check("service2", {9'b0, service2}, {9'b0, es2});
        coin_hi    += int'(player1[8]);
        coin_rises += int'(player1[8] && !coin_obs_prev);
        coin_obs_prev = player1[8];
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_key(input logic [7:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    task automatic clear_coin_count();
        coin_hi    = 0;
        coin_rises = 0;
    endtask

    initial begin
        reset      = 1'b1;
        ps2_key    = 11'h400;
        joystick_0 = '0;
        joystick_1 = '0;
        coin_obs_prev = 1'b0;
        clear_coin_count();
        ticks(3);
        check("reset_p1", player1, 10'h0);

        // Release with toggle bit high: no phantom event.
        reset = 1'b0;
        ticks(10);
        check("idle_p1", player1, 10'h0);
        check("idle_p2", player2, 10'h0);

        // PS/2 up1 press: visible two edges later.
        press_key(8'h75, 1'b1);
        tick();
        check("up1_lat1", {9'b0, player1[3]}, 10'h0);
        tick();
        check("up1_lat2", {9'b0, player1[3]}, 10'h1);
        press_key(8'h75, 1'b0);
        ticks(2);
        check("up1_release", {9'b0, player1[3]}, 10'h0);

        // Conflict filter and joystick latency.
        joystick_0 = 11'h003;
        tick();
        check("lr_conflict", {8'b0, player1[1:0]}, 10'h0);
        joystick_0 = 11'h009;
        tick();
        check("right_up", {6'b0, player1[3:0]}, 10'h9);
        joystick_0 = 11'h00C;
        tick();
        check("ud_conflict", {6'b0, player1[3:0]}, 10'h0);
        joystick_0 = '0;
        tick();

        // Held coin: one pulse of P cycles; release and re-press gives another.
        clear_coin_count();
        joystick_0[8] = 1'b1;
        ticks(30);
        check("coin_hold_len", 10'(coin_hi), 10'(P));
        check("coin_hold_once", 10'(coin_rises), 10'h1);
        joystick_0[8] = 1'b0;
        ticks(3);
        clear_coin_count();
        joystick_0[8] = 1'b1;
        ticks(12);
        check("coin_repress_len", 10'(coin_hi), 10'(P));
        joystick_0[8] = 1'b0;
        ticks(15);

        // Re-press inside the lockout window is dropped.
        clear_coin_count();
        joystick_0[8] = 1'b1;
        ticks(2);
        joystick_0[8] = 1'b0;
        ticks(4);
        joystick_0[8] = 1'b1;
        ticks(2);
        joystick_0[8] = 1'b0;
        ticks(12);
        check("coin_gap_drop", 10'(coin_hi), 10'(P));
        check("coin_gap_once", 10'(coin_rises), 10'h1);

        // Reset mid-pulse, coin still held afterwards.
        joystick_0[8] = 1'b1;
        ticks(2);
        check("coin_mid_pulse", {9'b0, player1[8]}, 10'h1);
        reset = 1'b1;
        tick();
        check("coin_reset_drop", {9'b0, player1[8]}, 10'h0);
        reset = 1'b0;
        clear_coin_count();
        ticks(15);
        check("coin_held_after_reset", 10'(coin_hi), 10'h0);
        joystick_0[8] = 1'b0;
        ticks(2);
        clear_coin_count();
        joystick_0[8] = 1'b1;
        ticks(12);
        check("coin_after_reset_press", 10'(coin_hi), 10'(P));
        joystick_0[8] = 1'b0;
        ticks(15);

        // Pause toggling from player 2 joystick.
        joystick_1[9] = 1'b1;
        ticks(2);
        joystick_1[9] = 1'b0;
        ticks(2);
        check("pause2_on", {9'b0, player2[9]}, 10'h1);
        joystick_1[9] = 1'b1;
        ticks(2);
        joystick_1[9] = 1'b0;
        ticks(2);
        check("pause2_off", {9'b0, player2[9]}, 10'h0);

        // Key and joystick pause together count as one edge.
        press_key(8'h4D, 1'b1);
        joystick_0[9] = 1'b1;
        ticks(3);
        check("pause1_once", {9'b0, player1[9]}, 10'h1);
        press_key(8'h4D, 1'b0);
        joystick_0[9] = 1'b0;
        ticks(3);
        check("pause1_hold", {9'b0, player1[9]}, 10'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0)
                joystick_0 = 11'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 9) == 0)
                joystick_1 = 11'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 4) == 0)
                    press_key(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                else
                    press_key(key_code[$urandom_range(0, NKEYS-1)], 1'($urandom_range(0, 1)));
                ps2_key[8] = 1'($urandom_range(0, 1));
            end
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
